// File: rtl/ramg6_pkg.sv
// Shared definitions for the ramg6 RAM block: stream FSM encoding, default
// geometry and the CPU write lane-enable decode.
package ramg6_pkg;

    localparam int default_num_kbytes = 128;
    localparam int addr_width         = $clog2(default_num_kbytes * 1024);
    localparam int word_addr_width    = addr_width - 2;

    typedef enum logic {
        IDLE,
        RUN
    } stream_state_t;

    // be=1 wins over hw; half-word writes ignore the byte-offset bit.
    function automatic logic [3:0] lane_enables(input logic be, input logic hw,
                                                input logic [1:0] lsb);
        if (be)
            return 4'b0001 << lsb;
        else if (hw)
            return lsb[1] ? 4'b1100 : 4'b0011;
        else
            return 4'b1111;
    endfunction

endpackage

// File: rtl/ramg6_fifo.sv
// Prefetch FIFO for the stream channel; head word is shown combinationally and
// a flush empties it in one cycle.
module ramg6_fifo #(
    parameter int depth = 4,
    parameter int width = 32,
    localparam int pw   = $clog2(depth),
    localparam int cw   = pw + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [width-1:0] wdata,
    input  logic             pop,
    output logic [width-1:0] rdata,
    output logic [cw-1:0]    count,
    output logic             empty
);

    logic [width-1:0] mem [depth];
    logic [pw-1:0]    wr_ptr;
    logic [pw-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + pw'(1);
            if (pop)
                rd_ptr <= rd_ptr + pw'(1);
            case ({push, pop})
                2'b10:   count <= count + cw'(1);
                2'b01:   count <= count - cw'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/ramg6_lane.sv
// One byte-wide lane of the main array, clocked on the falling edge so a read
// issued at a rising edge is available before the next rising edge.
module ramg6_lane #(
    parameter int depth = 32768,
    parameter int aw    = 15
) (
    input  logic          clk,
    input  logic          we,
    input  logic [aw-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [depth];

    // NOTE: the storage array has no reset; clearing it would force the tools
    // to build it from flops instead of block RAM.
    always_ff @(negedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ramg6.sv
// Byte-lane RAM with a CPU port and a burst read stream that borrows the
// array only in cycles the CPU leaves idle.
module ramg6
    import ramg6_pkg::*;
#(
    parameter int num_kbytes = default_num_kbytes,
    parameter int fifo_depth = 4,
    parameter int len_width  = 16,
    localparam int a_w       = $clog2(num_kbytes * 1024),
    localparam int wa_w      = a_w - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd,
    input  logic                 wr,
    input  logic                 be,
    input  logic                 hw,
    input  logic [a_w-1:0]       addr,
    input  logic [31:0]          data_in,
    output logic [31:0]          data_out,
    input  logic                 st_start,
    input  logic                 st_abort,
    input  logic [wa_w-1:0]      st_base,
    input  logic [len_width-1:0] st_len,
    output logic                 st_busy,
    output logic                 st_done,
    output logic                 st_valid,
    input  logic                 st_ready,
    output logic [31:0]          st_data
);

    localparam int num_words = num_kbytes * 256;
    localparam int cnt_w     = $clog2(fifo_depth) + 1;

    stream_state_t        state, state_next;
    logic [wa_w-1:0]      waddr;
    logic [len_width-1:0] remaining;
    logic                 done_q, done_next;
    logic                 start_burst;
    logic                 finish;
    logic                 cpu_act;
    logic                 issue;
    logic                 pop;
    logic                 fifo_empty;
    logic [cnt_w-1:0]     fifo_count;
    logic [wa_w-1:0]      mem_addr;
    logic [3:0]           lane_we;
    logic [31:0]          lane_q;

    assign cpu_act  = rd | wr;
    assign mem_addr = cpu_act ? addr[a_w-1:2] : waddr;
    assign lane_we  = wr ? lane_enables(be, hw, addr[1:0]) : 4'b0000;

    // A word read in an issue cycle lands in the FIFO at the closing rising
    // edge, so at most one read is ever in flight and it is covered by count.
    assign issue = (state == RUN) && !cpu_act && !st_abort && (remaining != '0)
                   && (fifo_count < cnt_w'(fifo_depth));
    assign pop   = st_valid & st_ready;

    assign finish = (state == RUN) && (remaining == '0) &&
                    ((fifo_count == '0) || ((fifo_count == cnt_w'(1)) && pop));

    always_comb begin
        state_next  = state;
        done_next   = 1'b0;
        start_burst = 1'b0;
        if (st_abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (st_start) begin
                        if (st_len != '0) begin
                            state_next  = RUN;
                            start_burst = 1'b1;
                        end else begin
                            done_next = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (finish) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waddr     <= '0;
            remaining <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= done_next;
            if (start_burst) begin
                waddr     <= st_base;
                remaining <= st_len;
            end else if (issue) begin
                waddr     <= (waddr == wa_w'(num_words - 1)) ? '0 : waddr + wa_w'(1);
                remaining <= remaining - len_width'(1);
            end
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        ramg6_lane #(
            .depth(num_words),
            .aw   (wa_w)
        ) u_lane (
            .clk  (clk),
            .we   (lane_we[i]),
            .addr (mem_addr),
            .wdata(data_in[8*i +: 8]),
            .rdata(lane_q[8*i +: 8])
        );
    end

    ramg6_fifo #(
        .depth(fifo_depth),
        .width(32)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .flush(st_abort),
        .push (issue),
        .wdata(lane_q),
        .pop  (pop),
        .rdata(st_data),
        .count(fifo_count),
        .empty(fifo_empty)
    );

    assign data_out = lane_q;
    assign st_busy  = (state == RUN);
    assign st_done  = done_q;
    assign st_valid = !fifo_empty;

endmodule

// File: tb/tb_ramg6.sv
// Directed bench for ramg6: CPU lane writes, stream bursts, back-pressure,
// CPU interleave, address wrap, abort and zero-length bursts.
module tb_ramg6;

    localparam int a_w   = 17;
    localparam int wa_w  = 15;
    localparam int len_w = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             rd, wr, be, hw;
    logic [a_w-1:0]   addr;
    logic [31:0]      data_in;
    logic [31:0]      data_out;
    logic             st_start, st_abort;
    logic [wa_w-1:0]  st_base;
    logic [len_w-1:0] st_len;
    logic             st_busy, st_done, st_valid, st_ready;
    logic [31:0]      st_data;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cyc, first_valid_cyc, first_pop_cyc, last_pop_cyc, done_cyc;
    int          done_cnt, pops, ovf, max_count;
    logic [31:0] last_dout;
    logic [31:0] rdata;
    logic [31:0] sb[$];

    ramg6 dut (
        .clk     (clk),
        .rst     (rst),
        .rd      (rd),
        .wr      (wr),
        .be      (be),
        .hw      (hw),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .st_start(st_start),
        .st_abort(st_abort),
        .st_base (st_base),
        .st_len  (st_len),
        .st_busy (st_busy),
        .st_done (st_done),
        .st_valid(st_valid),
        .st_ready(st_ready),
        .st_data (st_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample everything shortly after the falling edge, then advance to just
    // past the next rising edge where the next inputs are driven.
    task automatic tick();
        logic [31:0] exp;
        @(negedge clk);
        #1;
        if (st_valid === 1'b1 && st_ready === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL stream_unexpected: observed %h expected no word", st_data);
            end
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("stream_data", st_data, exp);
            end
            pops++;
            last_pop_cyc = cyc;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
        end
        if (st_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (st_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (int'(dut.u_fifo.count) > max_count) max_count = int'(dut.u_fifo.count);
        if (dut.u_fifo.push === 1'b1 && dut.u_fifo.count == 3'd4 && !(st_valid && st_ready))
            ovf++;
        last_dout = data_out;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cpu_write(input logic [a_w-1:0] a, input logic [31:0] d,
                             input logic b, input logic h);
        wr = 1'b1; addr = a; data_in = d; be = b; hw = h;
        tick();
        wr = 1'b0; be = 1'b0; hw = 1'b0;
    endtask

    task automatic cpu_read(input logic [a_w-1:0] a, output logic [31:0] d);
        rd = 1'b1; addr = a;
        tick();
        rd = 1'b0;
        d = last_dout;
    endtask

    task automatic start_burst(input logic [wa_w-1:0] base, input logic [len_w-1:0] len);
        st_base = base; st_len = len; st_start = 1'b1;
        start_cyc = cyc; done_cnt = 0; pops = 0;
        first_valid_cyc = -1; first_pop_cyc = -1;
        tick();
        st_start = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check("burst_done_count", 32'(done_cnt), 32'd1);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("busy_after_done", {31'd0, st_busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0; be = 1'b0; hw = 1'b0;
        addr = '0; data_in = '0; st_start = 1'b0; st_abort = 1'b0;
        st_base = '0; st_len = '0; st_ready = 1'b0;
        done_cnt = 0; pops = 0; ovf = 0; max_count = 0;
        first_valid_cyc = -1; first_pop_cyc = -1; last_pop_cyc = 0; done_cyc = 0;
        repeat (3) tick();
        rst = 1'b0;

        check("rst_busy", {31'd0, st_busy}, 32'd0);
        check("rst_done", {31'd0, st_done}, 32'd0);
        check("rst_valid", {31'd0, st_valid}, 32'd0);
        check("rst_fifo_count", 32'(dut.u_fifo.count), 32'd0);
        check("rst_remaining", 32'(dut.remaining), 32'd0);
        check("rst_waddr", 32'(dut.waddr), 32'd0);

        // CPU lane enables
        cpu_write(17'h00040, 32'h11223344, 1'b0, 1'b0);
        cpu_write(17'h00041, 32'h0000AA00, 1'b1, 1'b0);
        cpu_read(17'h00040, rdata);
        check("byte_write_lane1", rdata, 32'h1122AA44);
        cpu_write(17'h00042, 32'hBEEF0000, 1'b0, 1'b1);
        cpu_read(17'h00040, rdata);
        check("half_write_upper", rdata, 32'hBEEFAA44);
        cpu_write(17'h00043, 32'h77000000, 1'b1, 1'b1);
        cpu_read(17'h00040, rdata);
        check("byte_beats_half", rdata, 32'h77EFAA44);
        cpu_write(17'h00041, 32'h0000CAFE, 1'b0, 1'b1);
        cpu_read(17'h00040, rdata);
        check("half_write_lower_odd", rdata, 32'h77EFCAFE);

        for (int i = 0; i < 8; i++) cpu_write(17'(i * 4), 32'(i), 1'b0, 1'b0);
        cpu_write(17'h1FFFC, 32'hDEADBEEF, 1'b0, 1'b0);

        // Full-rate burst
        for (int i = 0; i < 8; i++) sb.push_back(32'(i));
        st_ready = 1'b1;
        start_burst(15'd0, 16'd8);
        check("busy_after_start", {31'd0, st_busy}, 32'd1);
        run_until_done(40);
        check("first_valid_latency", 32'(first_valid_cyc - start_cyc), 32'd2);
        check("full_throughput", 32'(last_pop_cyc - first_pop_cyc), 32'd7);
        check("done_after_last_pop", 32'(done_cyc - last_pop_cyc), 32'd1);

        // Back-pressure, ignored restart and CPU writes ahead of / behind the stream
        for (int i = 0; i < 8; i++) sb.push_back(32'(i));
        sb[5] = 32'h00000055;
        st_ready = 1'b0;
        start_burst(15'd0, 16'd8);
        repeat (10) tick();
        check("stall_fifo_full", 32'(dut.u_fifo.count), 32'd4);
        check("stall_remaining", 32'(dut.remaining), 32'd4);
        st_base = 15'd4; st_len = 16'd2; st_start = 1'b1;
        tick();
        st_start = 1'b0;
        check("busy_restart_ignored", 32'(dut.remaining), 32'd4);
        cpu_write(17'h00014, 32'h00000055, 1'b0, 1'b0);
        cpu_write(17'h00004, 32'h00000099, 1'b0, 1'b0);
        st_ready = 1'b1;
        run_until_done(40);
        cpu_write(17'h00014, 32'd5, 1'b0, 1'b0);
        cpu_write(17'h00004, 32'd1, 1'b0, 1'b0);

        // CPU reads every other cycle during a burst
        for (int i = 0; i < 8; i++) sb.push_back(32'(i));
        start_burst(15'd0, 16'd8);
        for (int k = 0; k < 60 && done_cnt == 0; k++) begin
            rd = (k % 2 == 0);
            addr = 17'((k % 8) * 4);
            tick();
            if (k % 2 == 0) check("cpu_read_interleave", last_dout, 32'(k % 8));
        end
        rd = 1'b0;
        check("interleave_done", 32'(done_cnt), 32'd1);
        check("interleave_drained", 32'(sb.size()), 32'd0);
        check("interleave_delayed", {31'd0, (done_cyc - start_cyc) > 10}, 32'd1);

        // Address wrap from the top word
        sb.push_back(32'hDEADBEEF); sb.push_back(32'd0); sb.push_back(32'd1);
        start_burst(15'h7FFF, 16'd3);
        run_until_done(30);

        // Abort after two words
        for (int i = 0; i < 8; i++) sb.push_back(32'(i));
        start_burst(15'd0, 16'd8);
        for (int n = 0; n < 20 && pops < 2; n++) tick();
        st_ready = 1'b0; st_abort = 1'b1;
        tick();
        st_abort = 1'b0;
        check("abort_valid", {31'd0, st_valid}, 32'd0);
        check("abort_busy", {31'd0, st_busy}, 32'd0);
        check("abort_fifo_flushed", 32'(dut.u_fifo.count), 32'd0);
        repeat (4) tick();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_pops", 32'(pops), 32'd2);
        sb.delete();

        // Abort wins over a simultaneous start
        st_abort = 1'b1;
        start_burst(15'd0, 16'd5);
        st_abort = 1'b0;
        check("abort_beats_start", {31'd0, st_busy}, 32'd0);
        tick();
        check("abort_start_valid", {31'd0, st_valid}, 32'd0);

        // Normal burst after abort
        st_ready = 1'b1;
        sb.push_back(32'd2); sb.push_back(32'd3); sb.push_back(32'd4);
        start_burst(15'd2, 16'd3);
        run_until_done(30);

        // Zero-length burst
        start_burst(15'd0, 16'd0);
        check("len0_done_pulse", {31'd0, st_done}, 32'd1);
        check("len0_busy", {31'd0, st_busy}, 32'd0);
        tick();
        tick();
        check("len0_done_count", 32'(done_cnt), 32'd1);
        check("len0_no_data", 32'(pops), 32'd0);

        check("fifo_never_overflowed", 32'(ovf), 32'd0);
        check("fifo_max_count_bound", {31'd0, max_count <= 4}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ramg6.md
Name: ramg6

Overview:
- Parametrised successor to the single-port byte-lane BRAM block. It keeps the CPU port: 32-bit words, word reads, byte writes and adds half-word writes.
- Adds a streaming read channel: a burst engine fetches consecutive words into a small prefetch FIFO with a valid/ready handshake. Consumers are a display or DMA sink.
- The stream uses only cycles the CPU leaves idle. Sits on the CPU data bus in place of the main RAM.

Parameters:
- num_kbytes, 128, memory size in kB; addr_width = clog2(num_kbytes*1024).
- fifo_depth, 4, prefetch FIFO entries (power of two, >=2).
- len_width, 16, width of the burst word count.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- rd  in  1  CPU read strobe.
- wr  in  1  CPU write strobe.
- be  in  1  CPU byte access.
- hw  in  1  CPU half-word access.
- addr  in  addr_width  CPU byte address.
- data_in  in  32  CPU write data; the byte/half-word is already positioned in its lane.
- data_out  out  32  CPU read word.
- st_start  in  1  start a burst (pulse).
- st_abort  in  1  cancel the burst.
- st_base  in  addr_width-2  burst start word address.
- st_len  in  len_width  burst length in words.
- st_busy  out  1  burst in progress.
- st_done  out  1  one-cycle pulse when the last word is consumed.
- st_valid  out  1  FIFO head valid.
- st_ready  in  1  consumer accepts the head.
- st_data  out  32  FIFO head word.

Behaviour:
- Storage: four byte-wide lanes, each a depth-num_kbytes*256 array. The array is clocked on the falling edge of clk, so CPU read data is valid before the next rising edge. All control logic runs on the rising edge.
- Lane enables on write:
  - be=1: only the lane selected by addr[1:0].
  - be=0, hw=1: lanes 1:0 if addr[1]=0, lanes 3:2 if addr[1]=1. addr[0] is ignored.
  - be=0, hw=0: all four lanes.
  - be=1 takes priority over hw. Reads always return the full word.
- Port arbitration: the array address comes from the CPU when rd|wr, otherwise from the stream engine. The CPU always wins and never stalls. data_out is defined only in cycles with rd=1.
- Stream FSM states:
  - IDLE → RUN on st_start with st_len>0: latch st_base into waddr and st_len into remaining. st_busy=1 from the next cycle.
  - IDLE with st_start and st_len=0: st_done pulses the next cycle; no data is produced and the FSM stays in IDLE.
  - RUN issue rule: issue a read in a cycle when rd|wr=0, remaining>0, and (FIFO count + outstanding) < fifo_depth. On issue, decrement remaining and increment waddr. The word enters the FIFO at the following rising edge.
  - RUN → IDLE when remaining=0, nothing is outstanding, and the FIFO is empty after a pop. st_done pulses for exactly one cycle in that cycle and st_busy drops.
- Address wrap: waddr wraps from the top word to word 0 with no error.
- FIFO: a pop occurs when st_valid & st_ready. A push and a pop in the same cycle keep the count unchanged. st_data holds stable while st_valid=1 and st_ready=0. The FIFO can never overflow by construction; the bench asserts this.
- st_start while busy: ignored; no change of base or length.
- st_abort (any state): the next cycle is IDLE with the FIFO flushed, st_valid=0, any outstanding read discarded, and no st_done. If st_abort and st_start arrive together, abort wins.
- CPU write to an address the stream has not yet fetched: the stream returns the new value. Words already in the FIFO keep their old value.
- Reset values:
  - FSM IDLE; st_busy=0, st_done=0, st_valid=0.
  - FIFO pointers, count, remaining and waddr all 0.
  - st_data and data_out undefined. Memory contents are not cleared.
- Latency: first st_valid at the earliest 2 cycles after st_start, with no CPU traffic. Sustained throughput is 1 word/cycle with st_ready=1 and the CPU idle.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, RUN);
  - the lane-enable function (be, hw, addr[1:0]) → 4-bit mask;
  - localparams addr_width and word_addr_width.
- One sub-module, ramg6_fifo: a synchronous FIFO with count output, sized fifo_depth×32, with a flush input driven by abort.
- The byte-lane array is a second small module, ramg6_lane, instantiated four times.

Test Plan:
- Write 0x11223344 to word 0x10, then byte write data_in=0x0000AA00 at addr 0x41 → read of 0x40 returns 0x1122AA44.
- Half-word write data_in=0xBEEF0000 at addr 0x42 (hw=1, be=0) → read 0x40 returns 0xBEEFAA44; repeat with be=1 and hw=1 at addr 0x43 → only lane 3 changes.
- Fill words 0..7 with 0..7; st_start with base=0, len=8, st_ready=1, CPU idle → st_data 0..7 on 8 consecutive valid cycles, st_done one cycle after the last pop, st_busy low afterwards.
- Same burst with st_ready=0 for 10 cycles → exactly fifo_depth=4 words fetched, no overflow; releasing st_ready yields 0..7 in order with no loss or duplication.
- Same burst with CPU rd asserted every other cycle → stream data still 0..7; CPU read data correct each cycle; completion delayed.
- Burst base=top word, len=3 → data = mem[top], mem[0], mem[1]. A separate burst with st_abort after 2 words → st_valid=0 the next cycle, no st_done; a new st_start works normally. st_len=0 → st_done only.
